// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the md_seq multiply/divide sequencer.
//   - md_op_e   : md_Op encodings (MULTU, DIVU, MULT, DIV, MTHI, MTLO)
//   - md_state_e: sequencer FSM states
//   - MD_ITER   : radix-2 iterations per operation (equals operand width)
//   - STEP_ADD / STEP_SUB: step-unit op codes, same numbering as the ALU
package md_pkg;

  localparam int unsigned MD_WIDTH = 32;
  localparam int unsigned MD_ITER  = 32;
  localparam int unsigned STEP_W   = MD_WIDTH + 1;

  typedef enum logic [2:0] {
    MD_MULTU = 3'd0,
    MD_DIVU  = 3'd1,
    MD_MULT  = 3'd2,
    MD_DIV   = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_e;

  localparam logic [2:0] STEP_ADD = 3'd2;
  localparam logic [2:0] STEP_SUB = 3'd3;

endpackage

// File: rtl/md_addsub.sv
// md_addsub: combinational add/sub step unit shared by the multiply and
// divide iterations of md_seq.
// Ports:
//   a, b  : W-bit operands
//   op    : STEP_ADD (a+b) or STEP_SUB (a-b); any other code adds
//   sum   : W-bit result
//   carry : carry-out for add, borrow-out for subtract (1 = a < b)
module md_addsub
  import md_pkg::*;
#(
  parameter int unsigned W = STEP_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] w_res;

  always_comb begin
    if (op == STEP_SUB) begin
      w_res = {1'b0, a} - {1'b0, b};
    end else begin
      w_res = {1'b0, a} + {1'b0, b};
    end
  end

  assign sum   = w_res[W-1:0];
  assign carry = w_res[W];

endmodule

// File: rtl/md_seq.sv
// md_seq: multi-cycle multiply/divide sequencer holding the HI/LO registers.
// Radix-2 iteration (shift-add multiply, restoring divide) over one shared
// md_addsub step unit. Optional signed MULT/DIV: define SIGNED_MD_EN;
// without it ops 2/3 run as MULTU/DIVU.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   md_Start, md_Op   : launch request and op code (accepted only in IDLE)
//   md_Data1/md_Data2 : rs / rt operands
//   md_Busy           : high in RUN and DONE (ITER+1 cycles)
//   md_Done           : one-cycle pulse in the cycle HI/LO are written
//   md_HI / md_LO     : architectural HI/LO registers
module md_seq
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned ITER  = MD_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_Start,
  input  logic [2:0]       md_Op,
  input  logic [WIDTH-1:0] md_Data1,
  input  logic [WIDTH-1:0] md_Data2,
  output logic             md_Busy,
  output logic             md_Done,
  output logic [WIDTH-1:0] md_HI,
  output logic [WIDTH-1:0] md_LO
);

  localparam int unsigned      CW   = $clog2(ITER);
  localparam logic [CW-1:0]    LAST = CW'(ITER - 1);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic             w_accept;

  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_acc;   // product high half / partial remainder
  logic [WIDTH-1:0] r_q;     // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] r_opb;   // multiplicand or divisor
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_absa;
  logic [WIDTH-1:0] w_absb;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_b;
  logic [2:0]       w_op;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    md_Busy     = 1'b0;
    md_Done     = 1'b0;
    case (r_state)
      IDLE: begin
        // ops 0..3 are exactly those with md_Op[2] clear
        if (md_Start && !md_Op[2]) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        md_Busy = 1'b1;
        if (r_cnt == LAST) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        md_Busy     = 1'b1;
        md_Done     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef SIGNED_MD_EN
  logic             w_sop;
  logic             w_na;
  logic             w_nb;
  logic             r_neg_q;   // negate product / quotient
  logic             r_neg_r;   // negate remainder (dividend sign)
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_sop  = md_Op[1];
  assign w_na   = w_sop & md_Data1[WIDTH-1];
  assign w_nb   = w_sop & md_Data2[WIDTH-1];
  assign w_absa = w_na ? (~md_Data1 + 1'b1) : md_Data1;
  assign w_absb = w_nb ? (~md_Data2 + 1'b1) : md_Data2;

  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;

  always_comb begin
    if (r_is_div) begin
      w_res_hi = r_neg_r ? (~r_acc + 1'b1) : r_acc;
      w_res_lo = r_neg_q ? (~r_q + 1'b1) : r_q;
    end else begin
      w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_na ^ w_nb;
      r_neg_r <= w_na;
    end
  end
`else
  assign w_absa   = md_Data1;
  assign w_absb   = md_Data2;
  assign w_res_hi = r_acc;
  assign w_res_lo = r_q;
`endif

  // Multiply adds the multiplicand only when the multiplier LSB is set, by
  // zeroing b; divide always trial-subtracts the divisor from the shifted
  // remainder {r_acc, next dividend bit}.
  always_comb begin
    if (r_is_div) begin
      w_a  = {r_acc, r_q[WIDTH-1]};
      w_b  = {1'b0, r_opb};
      w_op = STEP_SUB;
    end else begin
      w_a  = {1'b0, r_acc};
      w_b  = r_q[0] ? {1'b0, r_opb} : '0;
      w_op = STEP_ADD;
    end
  end

  md_addsub #(
    .W (WIDTH + 1)
  ) u_addsub (
    .a     (w_a),
    .b     (w_b),
    .op    (w_op),
    .sum   (w_sum),
    .carry (w_carry)
  );

  // Datapath and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_div <= md_Op[0];
            r_acc    <= '0;
            r_cnt    <= '0;
            r_opb    <= md_Op[0] ? w_absb : w_absa;
            r_q      <= md_Op[0] ? w_absa : w_absb;
          end else if (md_Start && (md_Op == MD_MTHI)) begin
            r_hi <= md_Data1;
          end else if (md_Start && (md_Op == MD_MTLO)) begin
            r_lo <= md_Data1;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            // borrow clear: keep difference; else restore (shifted value
            // is below the divisor so its top bit is zero)
            r_acc <= w_carry ? w_a[WIDTH-1:0] : w_sum[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], ~w_carry};
          end else begin
            r_acc <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end
        end
        DONE: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign md_HI = r_hi;
  assign md_LO = r_lo;

endmodule

// File: tb/tb_md_seq.sv
module tb_md_seq;

  logic        clk;
  logic        reset;
  logic        md_Start;
  logic [2:0]  md_Op;
  logic [31:0] md_Data1;
  logic [31:0] md_Data2;
  logic        md_Busy;
  logic        md_Done;
  logic [31:0] md_HI;
  logic [31:0] md_LO;

  int checks = 0;
  int errors = 0;

  md_seq #(
    .WIDTH (32),
    .ITER  (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .md_Start (md_Start),
    .md_Op    (md_Op),
    .md_Data1 (md_Data1),
    .md_Data2 (md_Data2),
    .md_Busy  (md_Busy),
    .md_Done  (md_Done),
    .md_HI    (md_HI),
    .md_LO    (md_LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive a start pulse for one edge; returns at the first negedge after
  // the accepting edge (cycle 1 of the operation).
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_Start = 1'b1;
    md_Op    = op;
    md_Data1 = a;
    md_Data2 = b;
    @(negedge clk);
    md_Start = 1'b0;
  endtask

  // Bounded wait for md_Done; cyc is the cycle index (1 = first after start).
  task automatic wait_done(output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    for (int k = 1; k <= 40; k++) begin
      if (md_Done) begin
        seen = 1'b1;
        cyc  = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; md_Start = 1'b0; md_Op = '0; md_Data1 = '0; md_Data2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (md_Busy !== 1'b0 || md_Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: busy=%b done=%b expected 0 0", md_Busy, md_Done);
    end
    checks++;
    if (md_HI !== 32'h0 || md_LO !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo: HI=%h LO=%h expected 0 0", md_HI, md_LO);
    end
  endtask

  task automatic test_multu_max();
    int busy_cnt = 0;
    int done_cnt = 0;
    int first_done = 0;
    start_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin
        md_Data1 = 32'h00000002;
        md_Data2 = 32'h00000003;
      end
      if (md_Busy) busy_cnt++;
      if (md_Done) begin
        done_cnt++;
        if (first_done == 0) first_done = k;
      end
      @(negedge clk);
    end
    checks++;
    if (first_done !== 33) begin
      errors++;
      $display("FAIL multu_latency: done at cycle %0d expected 33", first_done);
    end
    checks++;
    if (busy_cnt !== 33 || done_cnt !== 1) begin
      errors++;
      $display("FAIL multu_busy: busy=%0d done=%0d expected 33 1", busy_cnt, done_cnt);
    end
    checks++;
    if (md_HI !== 32'hFFFFFFFE || md_LO !== 32'h00000001) begin
      errors++;
      $display("FAIL multu_max: HI=%h LO=%h expected fffffffe 00000001", md_HI, md_LO);
    end
  endtask

  task automatic test_divu();
    int cyc; bit seen;
    start_op(3'd1, 32'd100, 32'd7);
    wait_done(cyc, seen);
    checks++;
    if (!seen || cyc != 33) begin
      errors++;
      $display("FAIL divu_latency: seen=%0d cycle=%0d expected 1 33", seen, cyc);
    end
    @(negedge clk);
    checks++;
    if (md_HI !== 32'd2 || md_LO !== 32'd14 || md_Busy !== 1'b0) begin
      errors++;
      $display("FAIL divu_100_7: HI=%h LO=%h busy=%b expected 2 e 0", md_HI, md_LO, md_Busy);
    end
  endtask

  task automatic test_divzero();
    int cyc; bit seen;
    start_op(3'd1, 32'd5, 32'd0);
    wait_done(cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || cyc != 33 || md_HI !== 32'd5 || md_LO !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL divu_by_zero: seen=%0d cyc=%0d HI=%h LO=%h expected 1 33 5 ffffffff",
               seen, cyc, md_HI, md_LO);
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    md_Start = 1'b1; md_Op = 3'd4; md_Data1 = 32'h12345678;
    @(negedge clk);
    checks++;
    if (md_HI !== 32'h12345678 || md_Done !== 1'b0 || md_Busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: HI=%h done=%b busy=%b expected 12345678 0 0", md_HI, md_Done, md_Busy);
    end
    md_Op = 3'd5; md_Data1 = 32'hCAFEF00D;
    @(negedge clk);
    md_Start = 1'b0;
    checks++;
    if (md_LO !== 32'hCAFEF00D || md_HI !== 32'h12345678 || md_Done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: HI=%h LO=%h done=%b expected 12345678 cafef00d 0", md_HI, md_LO, md_Done);
    end
  endtask

  task automatic test_noop();
    @(negedge clk);
    md_Start = 1'b1; md_Op = 3'd6; md_Data1 = 32'h11111111; md_Data2 = 32'h2;
    @(negedge clk);
    md_Op = 3'd7;
    @(negedge clk);
    md_Start = 1'b0;
    checks++;
    if (md_Busy !== 1'b0 || md_HI !== 32'h12345678 || md_LO !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL noop_ops: busy=%b HI=%h LO=%h expected 0 12345678 cafef00d", md_Busy, md_HI, md_LO);
    end
  endtask

  task automatic test_start_ignored();
    int done_cnt = 0;
    start_op(3'd1, 32'd1000, 32'd10);
    for (int k = 1; k <= 45; k++) begin
      if (k == 10) begin
        md_Start = 1'b1; md_Op = 3'd0; md_Data1 = 32'd3; md_Data2 = 32'd4;
      end else if (k == 11) begin
        md_Op = 3'd4; md_Data1 = 32'hDEADBEEF;
      end else if (k == 12) begin
        md_Start = 1'b0;
      end
      if (md_Done) done_cnt++;
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 1 || md_Busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start: done_pulses=%0d busy=%b expected 1 0", done_cnt, md_Busy);
    end
    checks++;
    if (md_HI !== 32'd0 || md_LO !== 32'd100) begin
      errors++;
      $display("FAIL busy_result: HI=%h LO=%h expected 0 64", md_HI, md_LO);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit seen;
    start_op(3'd0, 32'd7, 32'd9);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (md_Busy !== 1'b0 || md_Done !== 1'b0 || md_HI !== 32'd0 || md_LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b HI=%h LO=%h expected 0 0 0 0",
               md_Busy, md_Done, md_HI, md_LO);
    end
    start_op(3'd0, 32'd7, 32'd9);
    wait_done(cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || md_HI !== 32'd0 || md_LO !== 32'd63) begin
      errors++;
      $display("FAIL multu_7x9: seen=%0d HI=%h LO=%h expected 1 0 3f", seen, md_HI, md_LO);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen;
    start_op(3'd0, 32'h00010000, 32'h00010001);
    wait_done(cyc, seen);
    start_op(3'd1, 32'hFFFFFFFF, 32'h00010000);
    wait_done(cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || md_HI !== 32'h0000FFFF || md_LO !== 32'h0000FFFF) begin
      errors++;
      $display("FAIL back_to_back: seen=%0d HI=%h LO=%h expected 1 ffff ffff", seen, md_HI, md_LO);
    end
  endtask

  task automatic test_signed();
    int cyc; bit seen;
`ifdef SIGNED_MD_EN
    start_op(3'd2, 32'hFFFFFFFD, 32'd5);
    wait_done(cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || md_HI !== 32'hFFFFFFFF || md_LO !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL mult_m3x5: HI=%h LO=%h expected ffffffff fffffff1", md_HI, md_LO);
    end
    start_op(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || md_HI !== 32'hFFFFFFFF || md_LO !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_m7d2: HI=%h LO=%h expected ffffffff fffffffd", md_HI, md_LO);
    end
    start_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || md_HI !== 32'h0 || md_LO !== 32'h80000000) begin
      errors++;
      $display("FAIL div_ovf: HI=%h LO=%h expected 0 80000000", md_HI, md_LO);
    end
    start_op(3'd3, 32'hFFFFFFFB, 32'd0);
    wait_done(cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || md_HI !== 32'hFFFFFFFB || md_LO !== 32'h00000001) begin
      errors++;
      $display("FAIL div_neg_by_zero: HI=%h LO=%h expected fffffffb 1", md_HI, md_LO);
    end
`else
    start_op(3'd2, 32'hFFFFFFFD, 32'd5);
    wait_done(cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || md_HI !== 32'h00000004 || md_LO !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL mult_alias: HI=%h LO=%h expected 4 fffffff1", md_HI, md_LO);
    end
    start_op(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc, seen);
    @(negedge clk);
    checks++;
    if (!seen || md_HI !== 32'h00000001 || md_LO !== 32'h7FFFFFFC) begin
      errors++;
      $display("FAIL div_alias: HI=%h LO=%h expected 1 7ffffffc", md_HI, md_LO);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_divu();
    test_divzero();
    test_mthi_mtlo();
    test_noop();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_signed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_seq.md
Name: md_seq

Overview:
- Multi-cycle multiply/divide sequencer for the CPU execute stage. Runs MIPS MULTU/DIVU, plus MULT/DIV when the signed option is compiled in, as a radix-2 iteration over a shared 33-bit add/sub step unit.
- Holds the architectural HI/LO registers and exposes a start/busy/done handshake so the pipeline can stall mfhi/mflo and new md ops.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- md_Start  in  1  pulse: launch the operation in md_Op; accepted only in IDLE.
- md_Op  in  3  0=MULTU, 1=DIVU, 2=MULT, 3=DIV, 4=MTHI, 5=MTLO, others=no-op.
- md_Data1  in  32  rs operand (multiplicand/dividend; MTHI/MTLO source).
- md_Data2  in  32  rt operand (multiplier/divisor).
- md_Busy  out  1  high while an accepted mult/div is in flight.
- md_Done  out  1  one-cycle pulse in the cycle HI/LO update.
- md_HI  out  32  HI register.
- md_LO  out  32  LO register.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, md_HI=0, md_LO=0, md_Busy=0, md_Done=0, counter=0. Reset mid-operation aborts at that edge; no partial write to HI/LO.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - md_Start with op 0..3 latches the operands, clears the partial accumulator and counter, and moves to RUN.
  - Op 4/5 writes md_Data1 to HI/LO at that edge, stays in IDLE, and does not raise md_Done.
  - Ops 6/7 are ignored.
- RUN:
  - One step per cycle. Multiply: conditional add of the multiplicand, then shift right. Divide: trial subtract, restore or keep, then shift left with a quotient bit.
  - Counter counts 0..ITER-1; at ITER-1 go to DONE.
- DONE:
  - HI/LO update at the end of this cycle, with md_Done=1 during it; next state IDLE.
  - Multiply: {HI,LO} = 64-bit product. Divide: LO = quotient, HI = remainder.
- md_Busy=1 in RUN and DONE, i.e. for ITER+1 = 33 cycles after the accepting edge. New results are visible on md_HI/md_LO in the cycle after md_Done.
- md_Start during RUN/DONE is ignored entirely, including MTHI/MTLO; the pipeline must stall on md_Busy.
- Divide by zero (md_Data2=0): no trap. Result is LO=32'hFFFFFFFF, HI=dividend, produced naturally by the restoring algorithm and checked explicitly. Latency is unchanged.
- Operand changes after acceptance have no effect.
- Ops 2/3 without the option compiled in: treated as 0/1 (unsigned).

Optional Feature:
- Macro SIGNED_MD_EN.
- Defined:
  - Ops 2/3 take absolute values at acceptance, run the unsigned iteration, and fix signs in DONE.
  - Product negated if the operand signs differ. Quotient sign = XOR of the operand signs; remainder takes the dividend's sign.
  - 32'h80000000 / 32'hFFFFFFFF yields LO=32'h80000000, HI=0.
  - Signed divide by zero: LO = 32'hFFFFFFFF if the dividend is >= 0, else 32'h00000001; HI = dividend.
- Undefined: ops 2/3 alias to 0/1 and the sign logic is absent.

Decomposition:
- Package md_pkg: op encodings (MD_MULTU..MD_MTLO), FSM state encodings, ITER constant, step-op encoding (2=add, 3=sub, matching the ALU op numbering).
- One sub-module: md_addsub, a combinational 33-bit add/sub step unit (inputs a, b, op; outputs sum, carry), instantiated once and shared by the multiply and divide paths.

Test Plan:
- MULTU: 32'hFFFFFFFF x 32'hFFFFFFFF -> md_Done exactly 33 cycles after the start edge; HI=32'hFFFFFFFE, LO=32'h00000001; md_Busy high 33 cycles.
- DIVU: 100 / 7 -> LO=14, HI=2. DIVU 5 / 0 -> LO=32'hFFFFFFFF, HI=5.
- MTHI 32'h12345678 then MTLO 32'hCAFEF00D in IDLE -> HI/LO updated the next cycle; md_Done stays 0.
- md_Start with MULTU 3x4 at cycle 10 of a running DIVU -> ignored; DIVU result unchanged; no second md_Done.
- reset asserted at RUN cycle 15 of MULTU 7x9 -> next cycle IDLE, HI=LO=0, md_Busy=0; a subsequent MULTU 7x9 gives LO=63, HI=0.
- SIGNED_MD_EN: MULT -3 x 5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1. DIV -7 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
